iq_binner: RTL

IQ_BINNER -- requirements
Module: iq_binner

---
 rtl/iq_binner.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/iq_binner.sv
//==============================================================================
// Module      : iq_binner
// Description : 2-D histogram binner for integrated I/Q shot results.
//               Each accepted (I,Q) sample is mapped onto an X/Y grid of
//               bins by repeated subtraction of the bin width, then the
//               matching histogram entry is incremented (saturating).
//               The histogram lives in a single-port-write / single-read
//               RAM of 2^ADDR_W entries that is zeroed by a CLEAR pass
//               after reset or on request.
// Ports       :
//   clk100                 system clock, all logic on rising edge
//   reset                  synchronous active-high reset
//   iq_valid, i_val, q_val sample strobe and signed I/Q values
//   x/y_bin_min            signed lower edge of the bin grid
//   x/y_bin_width          unsigned bin width
//   x/y_bin_num            number of bins per axis (0..31)
//   clear                  histogram and counter clear request (IDLE only)
//   rd_en, rd_addr         histogram readout request
//   rd_data, rd_valid      readout result, one cycle after the request
//   busy                   high whenever the block is not IDLE
//   total/oor/drop_count   binned / out-of-range / dropped sample counters
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module iq_binner #(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 10
) (
    input  logic                clk100,
    input  logic                reset,
    input  logic                iq_valid,
    input  logic signed [31:0]  i_val,
    input  logic signed [31:0]  q_val,
    input  logic signed [15:0]  x_bin_min,
    input  logic signed [15:0]  y_bin_min,
    input  logic        [15:0]  x_bin_width,
    input  logic        [15:0]  y_bin_width,
    input  logic        [4:0]   x_bin_num,
    input  logic        [4:0]   y_bin_num,
    input  logic                clear,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic                busy,
    output logic [31:0]         total_count,
    output logic [31:0]         oor_count,
    output logic [31:0]         drop_count
);

    localparam int              c_DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CALC  = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    // Per-axis binning state. The offset is kept unsigned once it has been
    // checked non-negative; bit 32 doubles as the sign of the initial offset.
    typedef struct packed {
        logic [32:0] off;
        logic [4:0]  idx;
        logic        done;
        logic        oor;
    } axis_t;

    // One iteration of the repeated-subtraction divider for one axis.
    function automatic axis_t axis_step(input axis_t cur, input logic [15:0] w,
                                        input logic [4:0] n);
        axis_t nxt;
        nxt = cur;
        if (!cur.done) begin
            if (cur.off[32] || (w == 16'd0) || (n == 5'd0)) begin
                nxt.oor  = 1'b1;
                nxt.done = 1'b1;
            end else if (cur.off >= {17'd0, w}) begin
                if (cur.idx == n - 5'd1) begin
                    nxt.oor  = 1'b1;
                    nxt.done = 1'b1;
                end else begin
                    nxt.off = cur.off - {17'd0, w};
                    nxt.idx = cur.idx + 5'd1;
                end
            end else begin
                nxt.done = 1'b1;
            end
        end
        return nxt;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    axis_t               x_ax_q, x_ax_d, y_ax_q, y_ax_d;
    logic [15:0]         x_w_q, x_w_d, y_w_q, y_w_d;
    logic [4:0]          x_num_q, x_num_d, y_num_q, y_num_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         total_q, total_d, oor_q, oor_d, drop_q, drop_d;
    logic                rd_valid_q, rd_valid_d;

    axis_t               x_step, y_step;
    logic [10:0]         bin_lin;

    logic                mem_we, mem_re;
    logic [ADDR_W-1:0]   mem_waddr, mem_raddr;
    logic [CNT_W-1:0]    mem_wdata;
    logic [CNT_W-1:0]    mem_rdata_q;
    logic [CNT_W-1:0]    mem [0:c_DEPTH-1];

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        x_ax_d     = x_ax_q;
        y_ax_d     = y_ax_q;
        x_w_d      = x_w_q;
        y_w_d      = y_w_q;
        x_num_d    = x_num_q;
        y_num_d    = y_num_q;
        addr_d     = addr_q;
        total_d    = total_q;
        oor_d      = oor_q;
        drop_d     = drop_q;
        rd_valid_d = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        mem_re     = 1'b0;
        mem_raddr  = rd_addr;

        x_step  = axis_step(x_ax_q, x_w_q, x_num_q);
        y_step  = axis_step(y_ax_q, y_w_q, y_num_q);
        bin_lin = 11'(y_step.idx) * 11'(x_num_q) + 11'(x_step.idx);

        // Any sample arriving outside IDLE is lost but accounted for.
        if (iq_valid && (state_q != ST_IDLE)) begin
            drop_d = drop_q + 32'd1;
        end

        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                    total_d    = '0;
                    oor_d      = '0;
                    drop_d     = '0;
                end else if (iq_valid) begin
                    // 33-bit signed differences cannot overflow.
                    x_ax_d.off  = {i_val[31], i_val} - {{17{x_bin_min[15]}}, x_bin_min};
                    y_ax_d.off  = {q_val[31], q_val} - {{17{y_bin_min[15]}}, y_bin_min};
                    x_ax_d.idx  = '0;
                    y_ax_d.idx  = '0;
                    x_ax_d.done = 1'b0;
                    y_ax_d.done = 1'b0;
                    x_ax_d.oor  = 1'b0;
                    y_ax_d.oor  = 1'b0;
                    x_w_d       = x_bin_width;
                    y_w_d       = y_bin_width;
                    x_num_d     = x_bin_num;
                    y_num_d     = y_bin_num;
                    state_d     = ST_CALC;
                end else if (rd_en) begin
                    mem_re     = 1'b1;
                    mem_raddr  = rd_addr;
                    rd_valid_d = 1'b1;
                end
            end
            ST_CALC: begin
                x_ax_d = x_step;
                y_ax_d = y_step;
                if (x_step.done && y_step.done) begin
                    if (x_step.oor || y_step.oor) begin
                        oor_d   = oor_q + 32'd1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = ADDR_W'(bin_lin);
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                mem_re    = 1'b1;
                mem_raddr = addr_q;
                state_d   = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_wdata = (mem_rdata_q == c_CNT_MAX) ? c_CNT_MAX : mem_rdata_q + 1'b1;
                total_d   = total_q + 32'd1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            x_ax_q     <= '0;
            y_ax_q     <= '0;
            x_w_q      <= '0;
            y_w_q      <= '0;
            x_num_q    <= '0;
            y_num_q    <= '0;
            addr_q     <= '0;
            total_q    <= '0;
            oor_q      <= '0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            x_ax_q     <= x_ax_d;
            y_ax_q     <= y_ax_d;
            x_w_q      <= x_w_d;
            y_w_q      <= y_w_d;
            x_num_q    <= x_num_d;
            y_num_q    <= y_num_d;
            addr_q     <= addr_d;
            total_q    <= total_d;
            oor_q      <= oor_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Histogram RAM: no reset on the array so it maps onto block RAM; a
    // write decided in the reset cycle is suppressed so an interrupted
    // sample cannot land.
    always_ff @(posedge clk100) begin
        if (mem_we && !reset) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata_q <= mem[mem_raddr];
        end
    end

    // Readout data is only meaningful alongside rd_valid; forcing zero
    // otherwise keeps the output deterministic straight after reset.
    assign rd_data     = rd_valid_q ? mem_rdata_q : '0;
    assign rd_valid    = rd_valid_q;
    assign busy        = (state_q != ST_IDLE);
    assign total_count = total_q;
    assign oor_count   = oor_q;
    assign drop_count  = drop_q;

endmodule

`default_nettype wire
